// File: rtl/csr_writer_pkg.sv
// Shared types and defaults for the CSR writer and its companion read controller.
// Holds the conversion state enum, default matrix geometry and the bus word type.
package csr_writer_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    ROWPTR,
    DONE
  } csr_state_e;

  localparam int unsigned DEF_N_ROWS = 16;
  localparam int unsigned DEF_N_COLS = 16;

endpackage

// File: rtl/csr_writer.sv
// Streams a dense row-major matrix in and writes its CSR form (values, column
// indices, row pointers) out through two registered single-word write ports.
module csr_writer
  import csr_writer_pkg::*;
#(
  parameter int unsigned N_ROWS = DEF_N_ROWS,
  parameter int unsigned N_COLS = DEF_N_COLS
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [31:0] row_base,
  input  logic [31:0] wdata_col_base,
  input  logic [31:0] matrix_base,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] addr1,
  output logic [31:0] dataOut1,
  output logic        WR1,
  output logic [31:0] addr2,
  output logic [31:0] dataOut2,
  output logic        WR2,
  output logic        done,
  output logic [31:0] nnz
);

  csr_state_e state_q;
  word_t      row_base_q, col_base_q, mat_base_q;
  word_t      nnz_q, row_q, col_q;
  word_t      addr1_q, data1_q, addr2_q, data2_q;
  logic       wr1_q, wr2_q, done_q;

  logic last_col, last_row, elem_nz;

  assign last_col = (col_q == word_t'(N_COLS - 1));
  assign last_row = (row_q == word_t'(N_ROWS - 1));
  assign elem_nz  = (in_data != '0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      row_base_q <= '0;
      col_base_q <= '0;
      mat_base_q <= '0;
      nnz_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr1_q    <= '0;
      data1_q    <= '0;
      addr2_q    <= '0;
      data2_q    <= '0;
      wr1_q      <= 1'b0;
      wr2_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr1_q  <= 1'b0;
      wr2_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            row_base_q <= row_base;
            col_base_q <= wdata_col_base;
            mat_base_q <= matrix_base;
            nnz_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            state_q    <= INIT;
          end
        end
        INIT: begin
          addr1_q <= row_base_q;
          data1_q <= '0;
          wr1_q   <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (in_valid) begin
            if (elem_nz) begin
              addr2_q <= mat_base_q + nnz_q;
              data2_q <= in_data;
              wr2_q   <= 1'b1;
              addr1_q <= col_base_q + nnz_q;
              data1_q <= col_q;
              wr1_q   <= 1'b1;
              nnz_q   <= nnz_q + 32'd1;
            end
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 32'd1;
              // Port 1 is taken by the column write; defer the pointer one cycle.
              if (elem_nz) begin
                state_q <= ROWPTR;
              end else begin
                addr1_q <= row_base_q + row_q + 32'd1;
                data1_q <= nnz_q;
                wr1_q   <= 1'b1;
                if (last_row) state_q <= DONE;
              end
            end else begin
              col_q <= col_q + 32'd1;
            end
          end
        end
        ROWPTR: begin
          // row_q and nnz_q were already advanced by the accept that got us here.
          addr1_q <= row_base_q + row_q;
          data1_q <= nnz_q;
          wr1_q   <= 1'b1;
          state_q <= (row_q == word_t'(N_ROWS)) ? DONE : RUN;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == RUN);
  assign addr1    = addr1_q;
  assign dataOut1 = data1_q;
  assign WR1      = wr1_q;
  assign addr2    = addr2_q;
  assign dataOut2 = data2_q;
  assign WR2      = wr2_q;
  assign done     = done_q;
  assign nnz      = nnz_q;

endmodule
